// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle sequencer for the RISC-V core. Steps one instruction through
//   FETCH / DECODE / EXEC / MEM / WB so instruction and data accesses can
//   share a single-ported memory guarded by a ready handshake. Produces the
//   same datapath selects as the single-cycle ControlUnit, plus PC/IR write
//   enables, halt handling, sticky trap reporting and performance counters.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   opcode[6:0]        inst[6:0] from IR, latched in DECODE
//   zero               ALU zero flag (branch decision in EXEC)
//   mem_ready          memory completes the current request this cycle
//   halt_req           stop at the next instruction boundary
//   pc_we, pc_src      PC write enable / source (0: PC+4, 1: old_pc+imm)
//   ir_we              IR / old_pc write enable
//   mem_req, mem_instr memory request, 1 = fetch address from PC
//   memread .. regwrite datapath controls (ControlUnit meanings)
//   aluop[1:0]         0 add, 1 sub, 2 funct-decoded
//   halted, trap, trap_cause[1:0]  status (cause 1 illegal, 2 timeout)
//   cycle_cnt, instret_cnt         running cycle / retired-instr counters
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 ir_we,
  output logic                 mem_req,
  output logic                 mem_instr,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 alusrc,
  output logic                 aluSrcA,
  output logic                 adressSrc,
  output logic                 writeDataSrc,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic [1:0]           aluop,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_LWI  = 7'b0000100;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_SS   = 7'b0100100;

  // Last waiting cycle index: a request still unanswered here traps.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R)  || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_LW) || (op == OP_LWI) || (op == OP_SW)   || (op == OP_SS);
  endfunction

  state_t                state_q, state_d;
  logic [6:0]            opc_q, opc_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [1:0]            cause_q, cause_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic                  retire;

  logic is_load, is_store;
  logic sel_alusrc, sel_asrca, sel_adr, sel_wds;
  logic [1:0] sel_aluop;

  logic pc_we_s, pc_src_s, ir_we_s, mem_req_s, mem_instr_s, memread_s, memwrite_s;
  logic alusrc_s, asrca_s, adr_s, wds_s, memtoreg_s, regwrite_s, halted_s, trap_s;
  logic [1:0] aluop_s;

  assign is_load  = (opc_q == OP_LW) || (opc_q == OP_LWI);
  assign is_store = (opc_q == OP_SW) || (opc_q == OP_SS);

  // Per-class datapath selects derived from the latched opcode.
  always_comb begin
    sel_alusrc = 1'b0;
    sel_asrca  = 1'b0;
    sel_adr    = 1'b0;
    sel_wds    = 1'b0;
    sel_aluop  = 2'd0;
    case (opc_q)
      OP_R:                   sel_aluop  = 2'd2;
      OP_BEQ:                 sel_aluop  = 2'd1;
      OP_ADDI, OP_LW, OP_SW:  sel_alusrc = 1'b1;
      OP_LWI:                 sel_alusrc = 1'b0;
      OP_SS: begin
        sel_alusrc = 1'b1;
        sel_asrca  = 1'b1;
        sel_adr    = 1'b1;
        sel_wds    = 1'b1;
      end
      default:                sel_aluop  = 2'd0;
    endcase
  end

  // Next-state, timeout, trap cause and Moore/handshake outputs.
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    tmo_d       = 16'd0;
    cause_d     = cause_q;
    retire      = 1'b0;
    pc_we_s     = 1'b0;
    pc_src_s    = 1'b0;
    ir_we_s     = 1'b0;
    mem_req_s   = 1'b0;
    mem_instr_s = 1'b0;
    memread_s   = 1'b0;
    memwrite_s  = 1'b0;
    alusrc_s    = 1'b0;
    asrca_s     = 1'b0;
    adr_s       = 1'b0;
    wds_s       = 1'b0;
    memtoreg_s  = 1'b0;
    regwrite_s  = 1'b0;
    aluop_s     = 2'd0;
    halted_s    = 1'b0;
    trap_s      = 1'b0;

    // Selects stay stable through EXEC/MEM/WB so address and data paths hold.
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      alusrc_s = sel_alusrc;
      asrca_s  = sel_asrca;
      adr_s    = sel_adr;
      wds_s    = sel_wds;
      aluop_s  = sel_aluop;
    end else begin
      alusrc_s = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        // tmo_q is zero only on the first FETCH cycle, the boundary where halt is honoured.
        if ((tmo_q == 16'd0) && halt_req) begin
          state_d = S_HALT;
        end else begin
          mem_req_s   = 1'b1;
          mem_instr_s = 1'b1;
          if (mem_ready) begin
            pc_we_s = 1'b1;
            ir_we_s = 1'b1;
            state_d = S_DECODE;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'd2;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        if (opc_q == OP_BEQ) begin
          pc_we_s  = zero;
          pc_src_s = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_s  = 1'b1;
        memread_s  = is_load;
        memwrite_s = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WB: begin
        regwrite_s = 1'b1;
        memtoreg_s = is_load;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
        if (!halt_req) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_TRAP: begin
        trap_s  = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Counter next values: cycles freeze while halted or trapped.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if ((state_q != S_HALT) && (state_q != S_TRAP)) begin
      cycle_d = cycle_q + CNT_WIDTH'(1);
    end else begin
      cycle_d = cycle_q;
    end
    if (retire) begin
      instret_d = instret_q + CNT_WIDTH'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // State, opcode latch, timeout, cause and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= 7'd0;
      tmo_q     <= 16'd0;
      cause_q   <= 2'd0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Every output is held low while reset is asserted.
  assign pc_we        = pc_we_s     & ~rst;
  assign pc_src       = pc_src_s    & ~rst;
  assign ir_we        = ir_we_s     & ~rst;
  assign mem_req      = mem_req_s   & ~rst;
  assign mem_instr    = mem_instr_s & ~rst;
  assign memread      = memread_s   & ~rst;
  assign memwrite     = memwrite_s  & ~rst;
  assign alusrc       = alusrc_s    & ~rst;
  assign aluSrcA      = asrca_s     & ~rst;
  assign adressSrc    = adr_s       & ~rst;
  assign writeDataSrc = wds_s       & ~rst;
  assign memtoreg     = memtoreg_s  & ~rst;
  assign regwrite     = regwrite_s  & ~rst;
  assign aluop        = rst ? 2'd0 : aluop_s;
  assign halted       = halted_s    & ~rst;
  assign trap         = trap_s      & ~rst;
  assign trap_cause   = rst ? 2'd0 : cause_q;
  assign cycle_cnt    = rst ? '0 : cycle_q;
  assign instret_cnt  = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed, self-checking bench for multicycle_ctrl (TIMEOUT_CYCLES = 4).
//   Each cycle's expected control vector is queued when inputs are driven and
//   popped/compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_LWI  = 7'b0000100;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_SS   = 7'b0100100;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  typedef struct packed {
    logic       pc_we, pc_src, ir_we, mem_req, mem_instr, memread, memwrite;
    logic       alusrc, aluSrcA, adressSrc, writeDataSrc, memtoreg, regwrite;
    logic [1:0] aluop;
    logic       halted, trap;
    logic [1:0] cause;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
  logic        pc_we, pc_src, ir_we, mem_req, mem_instr, memread, memwrite;
  logic        alusrc, aluSrcA, adressSrc, writeDataSrc, memtoreg, regwrite;
  logic [1:0]  aluop, trap_cause;
  logic        halted, trap;
  logic [31:0] cycle_cnt, instret_cnt;

  int vectors = 0;
  int miscompares = 0;
  ctl_t  exp_q[$];
  string tag_q[$];

  multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .halt_req(halt_req), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .mem_req(mem_req), .mem_instr(mem_instr), .memread(memread), .memwrite(memwrite),
    .alusrc(alusrc), .aluSrcA(aluSrcA), .adressSrc(adressSrc),
    .writeDataSrc(writeDataSrc), .memtoreg(memtoreg), .regwrite(regwrite),
    .aluop(aluop), .halted(halted), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // Expected selects from the opcode class table.
  function automatic ctl_t sel(input logic [6:0] op);
    ctl_t c = '0;
    case (op)
      OP_R:                  c.aluop = 2'd2;
      OP_BEQ:                c.aluop = 2'd1;
      OP_ADDI, OP_LW, OP_SW: c.alusrc = 1'b1;
      OP_SS: begin
        c.alusrc = 1'b1; c.aluSrcA = 1'b1; c.adressSrc = 1'b1; c.writeDataSrc = 1'b1;
      end
      default: c.aluop = 2'd0;
    endcase
    return c;
  endfunction

  function automatic ctl_t e_none();
    ctl_t c = '0;
    return c;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.mem_instr = 1'b1; c.pc_we = rdy; c.ir_we = rdy;
    return c;
  endfunction

  function automatic ctl_t e_exec(input logic [6:0] op, input logic z);
    ctl_t c = sel(op);
    if (op == OP_BEQ) begin
      c.pc_we = z; c.pc_src = 1'b1;
    end
    return c;
  endfunction

  function automatic ctl_t e_mem(input logic [6:0] op);
    ctl_t c = sel(op);
    c.mem_req  = 1'b1;
    c.memread  = (op == OP_LW) || (op == OP_LWI);
    c.memwrite = (op == OP_SW) || (op == OP_SS);
    return c;
  endfunction

  function automatic ctl_t e_wb(input logic [6:0] op);
    ctl_t c = sel(op);
    c.regwrite = 1'b1;
    c.memtoreg = (op == OP_LW) || (op == OP_LWI);
    return c;
  endfunction

  function automatic ctl_t e_halt();
    ctl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_trap(input logic [1:0] cause);
    ctl_t c = '0;
    c.trap = 1'b1; c.cause = cause;
    return c;
  endfunction

  // One clock cycle: drive inputs, queue expectation, compare at the falling edge.
  task automatic step(input string tag, input logic r, input logic rdy, input logic z,
                      input logic h, input logic [6:0] op, input ctl_t e);
    ctl_t got, want;
    string t;
    rst = r; mem_ready = rdy; zero = z; halt_req = h; opcode = op;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = {pc_we, pc_src, ir_we, mem_req, mem_instr, memread, memwrite,
           alusrc, aluSrcA, adressSrc, writeDataSrc, memtoreg, regwrite,
           aluop, halted, trap, trap_cause};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int cyc, input int ret);
    vectors++;
    assert ((cycle_cnt === 32'(cyc)) && (instret_cnt === 32'(ret))) else begin
      miscompares++;
      $error("FAIL %s: observed cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
             tag, cycle_cnt, instret_cnt, cyc, ret);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // Reset: everything low even with active inputs.
    step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, OP_R, e_none());
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, OP_R, e_none());
    chk_cnt("rst_cnt", 0, 0);

    // add: FETCH DECODE EXEC WB
    step("add_f", 1'b0, 1'b1, 1'b0, 1'b0, OP_R, e_fetch(1'b1));
    step("add_d", 1'b0, 1'b1, 1'b0, 1'b0, OP_R, e_none());
    step("add_e", 1'b0, 1'b1, 1'b0, 1'b0, OP_R, e_exec(OP_R, 1'b0));
    step("add_w", 1'b0, 1'b1, 1'b0, 1'b0, OP_R, e_wb(OP_R));
    chk_cnt("add_cnt", 4, 1);

    // lw with three wait cycles in MEM (ready lands on the timeout limit cycle)
    step("lw_f",  1'b0, 1'b1, 1'b0, 1'b0, OP_LW, e_fetch(1'b1));
    step("lw_d",  1'b0, 1'b1, 1'b0, 1'b0, OP_LW, e_none());
    step("lw_e",  1'b0, 1'b1, 1'b0, 1'b0, OP_LW, e_exec(OP_LW, 1'b0));
    for (int i = 0; i < 3; i++)
      step("lw_mwait", 1'b0, 1'b0, 1'b0, 1'b0, OP_LW, e_mem(OP_LW));
    step("lw_mrdy", 1'b0, 1'b1, 1'b0, 1'b0, OP_LW, e_mem(OP_LW));
    step("lw_w",    1'b0, 1'b0, 1'b0, 1'b0, OP_LW, e_wb(OP_LW));
    chk_cnt("lw_cnt", 12, 2);

    // beq taken then not taken
    step("beq1_f", 1'b0, 1'b1, 1'b1, 1'b0, OP_BEQ, e_fetch(1'b1));
    step("beq1_d", 1'b0, 1'b0, 1'b1, 1'b0, OP_BEQ, e_none());
    step("beq1_e", 1'b0, 1'b0, 1'b1, 1'b0, OP_BEQ, e_exec(OP_BEQ, 1'b1));
    chk_cnt("beq1_cnt", 15, 3);
    step("beq0_f", 1'b0, 1'b1, 1'b0, 1'b0, OP_BEQ, e_fetch(1'b1));
    step("beq0_d", 1'b0, 1'b0, 1'b0, 1'b0, OP_BEQ, e_none());
    step("beq0_e", 1'b0, 1'b0, 1'b0, 1'b0, OP_BEQ, e_exec(OP_BEQ, 1'b0));
    chk_cnt("beq0_cnt", 18, 4);

    // Illegal opcode -> sticky trap, counters frozen
    step("ill_f", 1'b0, 1'b1, 1'b0, 1'b0, OP_BAD, e_fetch(1'b1));
    step("ill_d", 1'b0, 1'b1, 1'b0, 1'b0, OP_BAD, e_none());
    for (int i = 0; i < 10; i++)
      step("ill_trap", 1'b0, 1'(i % 2), 1'b1, 1'(i % 3 == 0), OP_SW, e_trap(2'd1));
    chk_cnt("ill_cnt", 20, 4);
    step("ill_rst", 1'b1, 1'b0, 1'b0, 1'b0, OP_R, e_none());
    chk_cnt("ill_rst_cnt", 0, 0);

    // Fetch timeout: four unanswered cycles, then trap with cause 2
    for (int i = 0; i < 4; i++)
      step("tmo_wait", 1'b0, 1'b0, 1'b0, 1'b0, OP_R, e_fetch(1'b0));
    step("tmo_trap0", 1'b0, 1'b1, 1'b0, 1'b0, OP_R, e_trap(2'd2));
    step("tmo_trap1", 1'b0, 1'b1, 1'b0, 1'b0, OP_R, e_trap(2'd2));
    chk_cnt("tmo_cnt", 4, 0);
    step("tmo_rst", 1'b1, 1'b0, 1'b0, 1'b0, OP_R, e_none());

    // Ready exactly at the limit wins: addi proceeds normally
    for (int i = 0; i < 3; i++)
      step("lim_wait", 1'b0, 1'b0, 1'b0, 1'b0, OP_ADDI, e_fetch(1'b0));
    step("lim_rdy", 1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, e_fetch(1'b1));
    step("lim_d",   1'b0, 1'b0, 1'b0, 1'b0, OP_ADDI, e_none());
    step("lim_e",   1'b0, 1'b0, 1'b0, 1'b0, OP_ADDI, e_exec(OP_ADDI, 1'b0));
    step("lim_w",   1'b0, 1'b0, 1'b0, 1'b0, OP_ADDI, e_wb(OP_ADDI));
    chk_cnt("lim_cnt", 7, 1);

    // halt_req mid-sw: store completes, then halt at the boundary
    step("sw_f", 1'b0, 1'b1, 1'b0, 1'b0, OP_SW, e_fetch(1'b1));
    step("sw_d", 1'b0, 1'b0, 1'b0, 1'b1, OP_SW, e_none());
    step("sw_e", 1'b0, 1'b0, 1'b0, 1'b1, OP_SW, e_exec(OP_SW, 1'b0));
    step("sw_m", 1'b0, 1'b1, 1'b0, 1'b1, OP_SW, e_mem(OP_SW));
    chk_cnt("sw_cnt", 11, 2);
    step("hlt_f",  1'b0, 1'b1, 1'b0, 1'b1, OP_SS, e_none());
    step("hlt_h0", 1'b0, 1'b1, 1'b0, 1'b1, OP_SS, e_halt());
    step("hlt_h1", 1'b0, 1'b1, 1'b0, 1'b1, OP_SS, e_halt());
    step("hlt_rel", 1'b0, 1'b1, 1'b0, 1'b0, OP_SS, e_halt());
    chk_cnt("hlt_cnt", 12, 2);

    // ss after resuming, with one MEM wait cycle
    step("ss_f",  1'b0, 1'b1, 1'b0, 1'b0, OP_SS, e_fetch(1'b1));
    step("ss_d",  1'b0, 1'b0, 1'b0, 1'b0, OP_SS, e_none());
    step("ss_e",  1'b0, 1'b0, 1'b0, 1'b0, OP_SS, e_exec(OP_SS, 1'b0));
    step("ss_m0", 1'b0, 1'b0, 1'b0, 1'b0, OP_SS, e_mem(OP_SS));
    step("ss_m1", 1'b0, 1'b1, 1'b0, 1'b0, OP_SS, e_mem(OP_SS));
    chk_cnt("ss_cnt", 17, 3);

    // lwi: register-addressed load, all selects low
    step("lwi_f", 1'b0, 1'b1, 1'b0, 1'b0, OP_LWI, e_fetch(1'b1));
    step("lwi_d", 1'b0, 1'b0, 1'b0, 1'b0, OP_LWI, e_none());
    step("lwi_e", 1'b0, 1'b0, 1'b0, 1'b0, OP_LWI, e_exec(OP_LWI, 1'b0));
    step("lwi_m", 1'b0, 1'b1, 1'b0, 1'b0, OP_LWI, e_mem(OP_LWI));
    step("lwi_w", 1'b0, 1'b0, 1'b0, 1'b0, OP_LWI, e_wb(OP_LWI));
    chk_cnt("lwi_cnt", 22, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the RISC-V core: runs one instruction as a series of FETCH/DECODE/EXEC/MEM/WB states.
- Lets instruction and data accesses share one single-ported memory with a ready handshake.
- Drives the same datapath selects the single-cycle ControlUnit produces today (alusrc, aluSrcA, adressSrc, writeDataSrc, memtoreg, regwrite, memread, memwrite).
- Adds PC/IR write enables, halt control, trap detection and retired-instruction/cycle counters.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ready before trapping (1..65535)
- CNT_WIDTH, 32, width of cycle_cnt and instret_cnt

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  inst[6:0] from IR (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- halt_req  in  1  request stop at next instruction boundary
- pc_we  out  1  PC register write enable
- pc_src  out  1  0: PC<=PC+4; 1: PC<=old_pc+ImmGen
- ir_we  out  1  instruction register / old_pc write enable
- mem_req  out  1  memory request
- mem_instr  out  1  1: address from PC (fetch); 0: data address path
- memread, memwrite, alusrc, aluSrcA, adressSrc, writeDataSrc, memtoreg, regwrite  out  1 each  datapath controls, same meanings as ControlUnit
- aluop  out  2  0 add, 1 sub, 2 funct-decoded
- halted  out  1  core stopped at boundary
- trap  out  1  sticky fault
- trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout
- cycle_cnt  out  CNT_WIDTH  cycles since reset while not halted/trapped
- instret_cnt  out  CNT_WIDTH  instructions retired

Behaviour:
- Reset (rst=1 at edge): state=FETCH.
  - Counters, trap, trap_cause, halted, opcode latch and timeout counter all 0.
  - While rst=1, every output is forced 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. Outputs are Moore on state and latched opcode, except pc_we/ir_we in FETCH and MEM advance, which gate on mem_ready.
- Opcode classes:
  - 0110011 R: aluop=2
  - 1100011 beq: aluop=1
  - 0010011 addi/slli: alusrc=1
  - 0000011 lw: alusrc=1
  - 0000100 lwi: alusrc=0
  - 0100011 sw: alusrc=1
  - 0100100 ss: alusrc=1, aluSrcA=1, adressSrc=1, writeDataSrc=1
  - Any other opcode is illegal.
- FETCH:
  - If halt_req=1 on entry cycle, go HALT (no request issued).
  - Else mem_req=1, mem_instr=1.
  - Cycle with mem_ready=1: ir_we=1, pc_we=1, pc_src=0, then DECODE.
- DECODE: latch opcode. Illegal goes to TRAP, cause=1. Legal goes to EXEC.
- EXEC: ALU selects driven.
  - beq: pc_we=zero, pc_src=1; instret+1; go FETCH.
  - R/addi: go WB.
  - Loads/stores: go MEM.
- MEM: mem_req=1, mem_instr=0; memread for lw/lwi, memwrite for sw/ss, held constant until mem_ready.
  - Loads on ready: go WB.
  - Stores on ready: instret+1, go FETCH.
- WB: regwrite=1 for exactly one cycle; memtoreg=1 for loads; instret+1; go FETCH.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES with mem_ready=0: go TRAP, cause=2, and drop mem_req the next cycle.
  - mem_ready on the same cycle as the limit wins (normal advance).
- HALT: halted=1, all controls 0. Return to FETCH the cycle after halt_req=0.
- TRAP: trap=1 and cause held, all controls 0. Leave only via rst.
- Counters: cycle_cnt increments every cycle not in HALT/TRAP and not in reset; both counters wrap modulo 2^CNT_WIDTH.
- mem_ready outside FETCH/MEM is ignored.
- regwrite/memwrite never assert in the same cycle. No control is asserted while rst=1.
- halt_req is sampled only in FETCH, so an instruction in progress always completes.

Test Plan:
- Reset, then add x4,x2,x2 with mem_ready=1 each request:
  - Expect FETCH→DECODE→EXEC→WB, regwrite pulse in cycle 4, instret_cnt=1, cycle_cnt=4.
- lw with mem_ready delayed 3 cycles in MEM:
  - memread and mem_req held for 4 cycles, then WB with memtoreg=1.
  - Total 8 cycles, instret=1.
- beq with zero=1, then zero=0:
  - First instruction: pc_we=1, pc_src=1 in EXEC.
  - Second instruction: pc_we=0 in EXEC.
  - Each instruction retires in 3 cycles.
- Opcode 7'b1111111 in DECODE:
  - Next cycle trap=1, trap_cause=1, all controls 0 for 10 cycles.
  - cycle_cnt frozen. rst clears to FETCH.
- TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH:
  - TRAP with cause=2 after the 4-cycle limit.
  - Repeat with mem_ready=1 exactly at the limit: normal DECODE.
- halt_req=1 asserted mid-sw:
  - The store completes with a single memwrite.
  - FETCH then enters HALT (halted=1, no mem_req).
  - Deassert: next fetch begins one cycle later.
